// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and source encoding for the register-file writeback arbiter.
// Default widths, the source enum and the register count live here.
package regfile_pkg;

    localparam int ADDRSIZE_DEF = 5;
    localparam int WORDSIZE_DEF = 32;
    localparam int NREGS        = 2 ** ADDRSIZE_DEF;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback channels (ALU, LSU) plus the registered register-file write port.
// Slave is the arbiter view; master is the execute/memory side.
interface regfile_wb_arbiter_if
    import regfile_pkg::*;
#(
    parameter int ADDRSIZE = ADDRSIZE_DEF,
    parameter int WORDSIZE = WORDSIZE_DEF
);
    logic                alu_valid;
    logic                alu_ready;
    logic [ADDRSIZE-1:0] alu_rd;
    logic [WORDSIZE-1:0] alu_data;
    logic                lsu_valid;
    logic                lsu_ready;
    logic [ADDRSIZE-1:0] lsu_rd;
    logic [WORDSIZE-1:0] lsu_data;
    logic                regwr;
    logic [ADDRSIZE-1:0] rd;
    logic [WORDSIZE-1:0] rddata;

    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        input  alu_ready, lsu_ready, regwr, rd, rddata
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        output alu_ready, lsu_ready, regwr, rd, rddata
    );
endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// Two-request round-robin arbiter; favoured source flips to the other one on every grant.
// Latency: grant is combinational from req and the favoured-source register.
// Backpressure: no grant while reset is asserted; the loser simply waits.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    src_e prio;

    always_comb begin
        gnt = 2'b00;
        if (rst_n) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (prio == SRC_LSU) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= SRC_ALU;
        end else if (gnt != 2'b00) begin
            prio <= gnt[0] ? SRC_LSU : SRC_ALU;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU/LSU writebacks onto the single register-file write port and keeps a busy scoreboard.
// Latency: grant in cycle N -> regwr/rd/rddata in N+1; hazard is combinational from busy.
// Backpressure: ready depends only on valid and the round-robin pointer. Optional WBARB_ERR_EN adds sticky err.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int ADDRSIZE = ADDRSIZE_DEF,
    parameter int WORDSIZE = WORDSIZE_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    regfile_wb_arbiter_if.slave      wb,
    input  logic                     issue_valid,
    input  logic [ADDRSIZE-1:0]      issue_rd,
    input  logic [ADDRSIZE-1:0]      chk_rs1,
    input  logic [ADDRSIZE-1:0]      chk_rs2,
    output logic                     hazard,
    output logic [(2**ADDRSIZE)-1:0] busy
`ifdef WBARB_ERR_EN
    ,
    output logic                     err
`endif
);
    localparam int NR = 2 ** ADDRSIZE;

    logic [1:0]          gnt;
    src_e                wsrc;
    logic                granted;
    logic                w_en;
    logic [ADDRSIZE-1:0] w_rd;
    logic [WORDSIZE-1:0] w_data;
    logic [NR-1:0]       busy_nxt;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({wb.lsu_valid, wb.alu_valid}),
        .gnt   (gnt)
    );

    assign wb.alu_ready = gnt[0];
    assign wb.lsu_ready = gnt[1];
    assign hazard       = busy[chk_rs1] | busy[chk_rs2];

    always_comb begin
        wsrc    = gnt[1] ? SRC_LSU : SRC_ALU;
        granted = |gnt;
        w_rd    = (wsrc == SRC_LSU) ? wb.lsu_rd   : wb.alu_rd;
        w_data  = (wsrc == SRC_LSU) ? wb.lsu_data : wb.alu_data;
        // x0 grants complete the handshake but never reach the register file
        w_en    = granted && (w_rd != '0);
    end

    // Set is applied after clear so a new in-flight producer keeps the register busy
    always_comb begin
        busy_nxt = busy;
        if (w_en) begin
            busy_nxt[w_rd] = 1'b0;
        end
        if (issue_valid) begin
            busy_nxt[issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb.regwr  <= 1'b0;
            wb.rd     <= '0;
            wb.rddata <= '0;
            busy      <= '0;
        end else begin
            wb.regwr <= w_en;
            if (w_en) begin
                wb.rd     <= w_rd;
                wb.rddata <= w_data;
            end
            busy <= busy_nxt;
        end
    end

`ifdef WBARB_ERR_EN
    logic err_wb;
    logic err_issue;

    always_comb begin
        err_wb    = w_en && !busy[w_rd];
        err_issue = issue_valid && (issue_rd != '0) && busy[issue_rd]
                    && !(w_en && (w_rd == issue_rd));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (err_wb || err_issue) begin
            err <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed plus randomized bench for regfile_wb_arbiter against a behavioural model.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int AW = ADDRSIZE_DEF;
    localparam int DW = WORDSIZE_DEF;
    localparam int NR = NREGS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.ADDRSIZE(AW), .WORDSIZE(DW)) wb ();

    logic          issue_valid;
    logic [AW-1:0] issue_rd;
    logic [AW-1:0] chk_rs1;
    logic [AW-1:0] chk_rs2;
    logic          hazard;
    logic [NR-1:0] busy;
`ifdef WBARB_ERR_EN
    logic          err;
`endif

    regfile_wb_arbiter #(.ADDRSIZE(AW), .WORDSIZE(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb          (wb.slave),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .chk_rs1     (chk_rs1),
        .chk_rs2     (chk_rs2),
        .hazard      (hazard),
        .busy        (busy)
`ifdef WBARB_ERR_EN
        ,
        .err         (err)
`endif
    );

    // Reference model: per-register busy flags, last granted source, sticky error
    bit mbusy [NR];
    int last_src;
    int last_g;
    bit merr;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic logic [NR-1:0] mbusy_vec();
        logic [NR-1:0] v;
        for (int i = 0; i < NR; i++) v[i] = mbusy[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mbusy[i] = 1'b0;
        last_src = 1;
        last_g   = -1;
        merr     = 1'b0;
    endtask

    task automatic idle_inputs();
        wb.alu_valid = 1'b0; wb.alu_rd = '0; wb.alu_data = '0;
        wb.lsu_valid = 1'b0; wb.lsu_rd = '0; wb.lsu_data = '0;
        issue_valid  = 1'b0; issue_rd = '0;
        chk_rs1      = '0;   chk_rs2  = '0;
    endtask

    task automatic set_alu(input logic v, input int r, input logic [DW-1:0] d);
        wb.alu_valid = v; wb.alu_rd = AW'(r); wb.alu_data = d;
    endtask

    task automatic set_lsu(input logic v, input int r, input logic [DW-1:0] d);
        wb.lsu_valid = v; wb.lsu_rd = AW'(r); wb.lsu_data = d;
    endtask

    // Entered at posedge+1 with inputs already driven; returns at the next posedge+1
    task automatic do_cycle();
        int            g;
        bit            wr;
        logic [AW-1:0] wrd;
        logic [DW-1:0] wdat;
        #2;
        if (wb.alu_valid && wb.lsu_valid) g = (last_src == 0) ? 1 : 0;
        else if (wb.alu_valid)            g = 0;
        else if (wb.lsu_valid)            g = 1;
        else                              g = -1;
        chk("alu_ready", wb.alu_ready, g == 0);
        chk("lsu_ready", wb.lsu_ready, g == 1);
        chk("hazard", hazard, mbusy[chk_rs1] | mbusy[chk_rs2]);
        wrd  = (g == 1) ? wb.lsu_rd   : wb.alu_rd;
        wdat = (g == 1) ? wb.lsu_data : wb.alu_data;
        wr   = (g >= 0) && (wrd != 0);
        if (wr && !mbusy[wrd]) merr = 1'b1;
        if (issue_valid && issue_rd != 0 && mbusy[issue_rd] && !(wr && wrd == issue_rd)) merr = 1'b1;
        if (wr) mbusy[wrd] = 1'b0;
        if (issue_valid && issue_rd != 0) mbusy[issue_rd] = 1'b1;
        if (g >= 0) last_src = g;
        last_g = g;
        @(posedge clk);
        #1;
        chk("regwr", wb.regwr, wr);
        if (wr) begin
            chk("rd", wb.rd, wrd);
            chk("rddata", wb.rddata, wdat);
        end
        chk("busy", busy, mbusy_vec());
`ifdef WBARB_ERR_EN
        chk("err", err, merr);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("rst_regwr", wb.regwr, 0);
        chk("rst_rd", wb.rd, 0);
        chk("rst_rddata", wb.rddata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_ready", wb.alu_ready, 0);
        chk("rst_lsu_ready", wb.lsu_ready, 0);
`ifdef WBARB_ERR_EN
        chk("rst_err", err, 0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bit a_pend;
        bit l_pend;
        idle_inputs();
        model_reset();
        // Ready must stay low under reset even with requests present
        set_alu(1'b1, 3, 32'h11);
        set_lsu(1'b1, 4, 32'h22);
        @(posedge clk);
        #1;
        do_reset();

        // Single ALU write, then idle: regwr drops, rd/rddata hold
        set_lsu(1'b0, 0, 0);
        set_alu(1'b1, 3, 32'h11);
        do_cycle();
        set_alu(1'b0, 0, 0);
        do_cycle();
        chk("rd_hold", wb.rd, 3);
        chk("rddata_hold", wb.rddata, 32'h11);

        // First contention after reset alternates starting with the ALU
        idle_inputs();
        do_reset();
        set_alu(1'b1, 1, 32'hA);
        set_lsu(1'b1, 2, 32'hB);
        for (int k = 0; k < 4; k++) begin
            do_cycle();
            chk("contention_rd", wb.rd, (k % 2 == 0) ? 1 : 2);
        end
        idle_inputs();

        // Scoreboard set/clear visible through hazard
        issue_valid = 1'b1; issue_rd = 5; chk_rs1 = 5;
        do_cycle();
        issue_valid = 1'b0;
        chk("busy5_set", busy[5], 1);
        do_cycle();
        set_lsu(1'b1, 5, 32'h55);
        do_cycle();
        set_lsu(1'b0, 0, 0);
        do_cycle();
        chk("busy5_clr", busy[5], 0);

        // Set beats clear on the same register
        issue_valid = 1'b1; issue_rd = 7;
        do_cycle();
        set_alu(1'b1, 7, 32'h77);
        do_cycle();
        chk("busy7_set_wins", busy[7], 1);

        // x0 handling
        set_alu(1'b1, 0, 32'hFF);
        issue_valid = 1'b1; issue_rd = 0;
        do_cycle();
        chk("busy0", busy[0], 0);
        idle_inputs();
        do_cycle();

        // Randomized traffic; a losing source holds its request until granted
        a_pend = 1'b0;
        l_pend = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!a_pend) set_alu(($urandom % 3) != 0, $urandom_range(0, NR - 1), $urandom);
            if (!l_pend) set_lsu(($urandom % 2) != 0, $urandom_range(0, NR - 1), $urandom);
            issue_valid = ($urandom % 3) == 0;
            issue_rd    = AW'($urandom_range(0, NR - 1));
            chk_rs1     = AW'($urandom_range(0, NR - 1));
            chk_rs2     = AW'($urandom_range(0, NR - 1));
            do_cycle();
            a_pend = wb.alu_valid && (last_g != 0);
            l_pend = wb.lsu_valid && (last_g != 1);
        end
        idle_inputs();
        do_cycle();

`ifdef WBARB_ERR_EN
        // Writeback to a non-busy register is flagged and sticks
        issue_valid = 1'b0;
        set_alu(1'b1, 9, 32'h99);
        if (mbusy[9]) begin
            do_cycle();
        end
        do_cycle();
        chk("err_set", err, 1);
        idle_inputs();
        do_cycle();
        do_cycle();
        chk("err_sticky", err, 1);
`endif

        // Back-to-back writes cut by an asynchronous reset
        set_alu(1'b1, 4, 32'h44);
        set_lsu(1'b1, 6, 32'h66);
        issue_valid = 1'b1; issue_rd = 10;
        do_cycle();
        issue_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_regwr", wb.regwr, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_alu_ready", wb.alu_ready, 0);
`ifdef WBARB_ERR_EN
        chk("midrst_err", err, 0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_cycle();
        chk("post_rst_alu_first", wb.rd, 4);
        do_cycle();
        chk("post_rst_lsu_next", wb.rd, 6);
        idle_inputs();
        do_cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Sequences the single write port (regwr/rd/rddata) of the register file between two writeback sources: ALU and load/store unit.
- Holds a per-register busy scoreboard, set at issue and cleared at writeback, and gives decode a combinational RAW-hazard flag for rs1/rs2.
- Sits between the execute/memory stages and register_file.

Parameters:
ADDRSIZE, 5, register address width; 2**ADDRSIZE registers.
WORDSIZE, 32, register data width.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous reset, active-low
alu_valid  input  1  ALU writeback request
alu_ready  output  1  ALU request granted this cycle
alu_rd  input  ADDRSIZE  ALU destination register
alu_data  input  WORDSIZE  ALU result
lsu_valid  input  1  LSU writeback request
lsu_ready  output  1  LSU request granted this cycle
lsu_rd  input  ADDRSIZE  LSU destination register
lsu_data  input  WORDSIZE  LSU load data
issue_valid  input  1  instruction with destination issued
issue_rd  input  ADDRSIZE  destination of the issued instruction
chk_rs1  input  ADDRSIZE  decode source 1
chk_rs2  input  ADDRSIZE  decode source 2
hazard  output  1  busy[chk_rs1] | busy[chk_rs2], combinational
busy  output  2**ADDRSIZE  scoreboard vector
regwr  output  1  register file write enable, registered
rd  output  ADDRSIZE  register file write address, registered
rddata  output  WORDSIZE  register file write data, registered

Behaviour:
- Reset (async, rst_n=0): regwr=0, rd=0, rddata=0, busy=0, round-robin pointer = ALU-favoured. alu_ready and lsu_ready are 0 during reset. Reset mid-transfer discards any pending registered write.
- Handshake: a transfer occurs when valid and ready are both 1 in the same cycle. Ready is combinational from valid and the pointer and never depends on downstream state; the register file absorbs one write per cycle.
- Arbitration:
  - Exactly one valid source: it is granted.
  - Both valid: grant the source not granted last time. First contention after reset goes to the ALU.
  - The pointer updates on every grant.
  - The losing source must hold valid, rd and data stable until it is granted.
- Latency: a grant in cycle N drives regwr=1 with rd/rddata equal to the granted rd/data during cycle N+1. With no grant in cycle N, regwr=0 in N+1; rd/rddata hold their last values.
- x0 writes: a grant with rd==0 completes the handshake, but regwr stays 0 in N+1 and busy is untouched.
- Scoreboard, updated at the clock edge:
  - issue_valid with issue_rd!=0 sets busy[issue_rd].
  - A granted writeback clears busy[rd].
  - Set and clear of the same register in the same cycle: set wins, because a new producer is in flight.
  - busy[0] is constantly 0.
  - Issue to an already-busy register leaves it busy; WAW is stalled upstream.
  - A writeback to a non-busy register is still written.
- hazard is combinational from the current busy state. The clear takes effect the cycle after the grant, which matches the write landing in the register file.

Optional Feature:
- Macro WBARB_ERR_EN.
- Defined: adds output err (1 bit), sticky, cleared only by reset. err sets at the clock edge after either of these:
  - A granted writeback to a register with busy=0 (rd!=0).
  - issue_valid to a register already busy with no same-cycle clear.
- Undefined: no err port and no checking logic; all other behaviour is identical.

Decomposition:
- Package regfile_pkg holds:
  - default ADDRSIZE/WORDSIZE constants
  - source enum SRC_ALU=0, SRC_LSU=1
  - a localparam for the register count (2**ADDRSIZE)
- One sub-module, rr_arbiter2: 2-request round-robin arbiter with grant vector and pointer state, instantiated once. Scoreboard and output register stay in the top.

Test Plan:
- Reset, then ALU valid rd=3 data=0x11 for one cycle, LSU idle → alu_ready=1; next cycle regwr=1, rd=3, rddata=0x11; cycle after, regwr=0.
- ALU and LSU both valid for 4 cycles (ALU rd=1 data=0xA, LSU rd=2 data=0xB, held until granted) → grants ALU, LSU, ALU, LSU; regwr writes rd 1,2,1,2 on consecutive cycles.
- issue_valid rd=5, then chk_rs1=5 → busy[5]=1 and hazard=1 from the next cycle. LSU writeback rd=5 granted in cycle N → hazard=0 in N+1.
- Same cycle: issue_valid rd=7 and granted ALU writeback rd=7 with busy[7]=1 → busy[7] stays 1.
- ALU rd=0 data=0xFF, valid → alu_ready=1, regwr stays 0, busy[0]=0; issue_valid rd=0 → busy unchanged.
- Two writes granted back-to-back, rst_n pulsed low mid-sequence → regwr, busy and the pointer clear immediately. After release, the first contention grants the ALU. With WBARB_ERR_EN, a writeback to non-busy rd=9 sets err=1 and it stays set until reset.
